// File: rtl/pkt_sw_pkg.sv
// Shared packet-switch definitions: output-port FSM encoding and metadata header layout.
// Used by the port controller, the arbiter and the input/metadata buffers.
package pkt_sw_pkg;

  localparam int META_W = 32;

  typedef logic [2:0] pkt_port_state_t;

  localparam pkt_port_state_t ST_IDLE    = 3'd0;
  localparam pkt_port_state_t ST_HEADER  = 3'd1;
  localparam pkt_port_state_t ST_STREAM  = 3'd2;
  localparam pkt_port_state_t ST_DISCARD = 3'd3;
  localparam pkt_port_state_t ST_DONE    = 3'd4;

  // Metadata word as it appears in the header beat (LSB-aligned on the egress bus).
  typedef struct packed {
    logic [7:0]  src_port;
    logic [7:0]  flags;
    logic [15:0] pkt_len;
  } pkt_hdr_t;

endpackage

// File: rtl/pkt_port_ctrl_if.sv
// AXI-Stream style handshake bundle used for the payload, metadata and egress links.
interface pkt_port_ctrl_if #(parameter int W = 8);
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [W-1:0] tdata;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// Single-stage egress register: loads when empty or draining, holds beat stable under back-pressure.
module axis_out_reg #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ld,
  input  logic [OUT_W-1:0] ld_data,
  input  logic             ld_last,
  output logic             loadable,
  pkt_port_ctrl_if.master  out_axis
);

  assign loadable = !out_axis.tvalid || out_axis.tready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_axis.tvalid <= 1'b0;
      out_axis.tdata  <= '0;
      out_axis.tlast  <= 1'b0;
    end else if (ld && loadable) begin
      out_axis.tvalid <= 1'b1;
      out_axis.tdata  <= ld_data;
      out_axis.tlast  <= ld_last;
    end else if (out_axis.tready) begin
      out_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_port_ctrl.sv
// Output-port controller: on grant, moves one packet (optional metadata header, truncated
// at MAX_BEATS) from the input buffer to the egress stream and pops one metadata entry.
module pkt_port_ctrl
  import pkt_sw_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 32,
  parameter int HDR_EN    = 1,
  parameter int MAX_BEATS = 1536
) (
  input  logic            clk,
  input  logic            resetn,
  pkt_port_ctrl_if.slave  buf_axis,
  pkt_port_ctrl_if.slave  meta_axis,
  pkt_port_ctrl_if.master out_axis,
  output logic            ready_transfer,
  input  logic            start_transfer,
  output logic            pkt_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_TRUNC = CNT_W'(MAX_BEATS - 1);

  pkt_port_state_t   state;
  logic [CNT_W-1:0]  beat_cnt;
  logic              last_seen, meta_pop, rdy_q, err_q;
  logic              loadable, ld, ld_last;
  logic [OUT_W-1:0]  ld_data;
  logic [IN_W-1:0]   pay_word;
  logic [META_W-1:0] meta_word;
  logic              buf_hs, out_last_hs, trunc, grant;

  assign pay_word  = buf_axis.tdata;
  assign meta_word = meta_axis.tdata;

  assign buf_axis.tready  = (state == ST_STREAM && loadable) || state == ST_DISCARD;
  assign meta_axis.tready = meta_pop;
  assign ready_transfer   = rdy_q;
  assign pkt_err          = err_q;

  assign buf_hs      = buf_axis.tvalid && buf_axis.tready;
  assign out_last_hs = out_axis.tvalid && out_axis.tready && out_axis.tlast;
  assign trunc       = beat_cnt == CNT_TRUNC && !buf_axis.tlast;
  assign grant       = state == ST_IDLE && start_transfer && rdy_q;

  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_last = 1'b0;
    case (state)
      ST_HEADER: begin
        ld      = 1'b1;
        ld_data = OUT_W'(meta_word);
      end
      ST_STREAM: begin
        ld      = buf_axis.tvalid;
        ld_data = OUT_W'(pay_word);
        ld_last = buf_axis.tlast || trunc;
      end
      default: ;
    endcase
  end

  axis_out_reg #(.OUT_W(OUT_W)) u_out_reg (
    .clk      (clk),
    .resetn   (resetn),
    .ld       (ld),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .loadable (loadable),
    .out_axis (out_axis)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      last_seen <= 1'b0;
      meta_pop  <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      meta_pop <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= state == ST_IDLE && !grant && meta_axis.tvalid && buf_axis.tvalid;
      // A truncated packet's forced-last beat can drain while still discarding input.
      if (out_last_hs) last_seen <= 1'b1;
      case (state)
        ST_IDLE: begin
          beat_cnt  <= '0;
          last_seen <= 1'b0;
          if (grant) state <= (HDR_EN != 0) ? ST_HEADER : ST_STREAM;
        end
        ST_HEADER:
          if (loadable) state <= ST_STREAM;
        ST_STREAM:
          if (buf_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (buf_axis.tlast) begin
              state <= ST_DONE;
            end else if (trunc) begin
              err_q <= 1'b1;
              state <= ST_DISCARD;
            end
          end
        ST_DISCARD:
          if (buf_hs && buf_axis.tlast) state <= ST_DONE;
        ST_DONE:
          if (last_seen || out_last_hs) begin
            meta_pop <= 1'b1;
            state    <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_port_ctrl.sv
// Randomised bench for pkt_port_ctrl: a header/truncating port and a plain back-to-back port,
// checked against a packet-level expected-beat model.
module tb_pkt_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn1, rstn2, start1, start2, rdy1, rdy2, err1, err2;

  pkt_port_ctrl_if #(.W(8))  buf1 (), buf2 ();
  pkt_port_ctrl_if #(.W(32)) meta1 (), meta2 (), out1 (), out2 ();

  pkt_port_ctrl #(.IN_W(8), .OUT_W(32), .HDR_EN(1), .MAX_BEATS(4)) dut1 (
    .clk(clk), .resetn(rstn1), .buf_axis(buf1), .meta_axis(meta1), .out_axis(out1),
    .ready_transfer(rdy1), .start_transfer(start1), .pkt_err(err1));

  pkt_port_ctrl #(.IN_W(8), .OUT_W(32), .HDR_EN(0), .MAX_BEATS(16)) dut2 (
    .clk(clk), .resetn(rstn2), .buf_axis(buf2), .meta_axis(meta2), .out_axis(out2),
    .ready_transfer(rdy2), .start_transfer(start2), .pkt_err(err2));

  int checks = 0, errors = 0, cyc = 0;

  // port 1 model state
  logic [8:0]  bq1[$];
  logic [31:0] mq1[$];
  logic [32:0] exp1[$];
  bit          trunc1[$];
  int          pops1 = 0, errs1 = 0, last_hs1 = 0, sent1 = 0, exp_errs1 = 0, tr_mode = 0;
  bit          stall1 = 0, gaps = 0, meta_en1 = 1, rand_start = 0, hs_b1 = 0;
  logic [33:0] prev1;

  // port 2 model state
  logic [8:0]  q2[$];
  logic [32:0] exp2[$];
  int          pops2 = 0, hs2 = 0, last_hs2 = 0;
  bit          per_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [32:0] e;
    bit t;
    @(negedge clk);
    if (stall1) chk("hold", {out1.tvalid, out1.tlast, out1.tdata}, prev1);
    if (out1.tvalid && out1.tready) begin
      if (exp1.size() == 0) chk("extra_beat1", 1, 0);
      else begin e = exp1.pop_front(); chk("beat1", {out1.tlast, out1.tdata}, e); end
      if (out1.tlast) last_hs1 = cyc;
    end
    stall1 = out1.tvalid && !out1.tready;
    prev1  = {out1.tvalid, out1.tlast, out1.tdata};
    hs_b1  = buf1.tvalid && buf1.tready;
    if (hs_b1) void'(bq1.pop_front());
    if (meta1.tready) begin
      pops1++;
      if (mq1.size() > 0) void'(mq1.pop_front());
      if (trunc1.size() == 0) chk("extra_pop1", 1, 0);
      else begin
        t = trunc1.pop_front();
        if (!t) chk("pop_lat", cyc - last_hs1, 1);
        else    chk("pop_order", cyc > last_hs1, 1);
      end
    end
    if (err1) errs1++;

    if (out2.tvalid && out2.tready) begin
      if (exp2.size() == 0) chk("extra_beat2", 1, 0);
      else begin e = exp2.pop_front(); chk("beat2", {out2.tlast, out2.tdata}, e); end
      if (per_chk && hs2 > 0) chk("period", cyc - last_hs2, 4);
      hs2++;
      last_hs2 = cyc;
    end
    if (buf2.tvalid && buf2.tready && q2.size() > 0) void'(q2.pop_front());
    if (meta2.tready) pops2++;

    @(posedge clk);
    #1;
    cyc++;
    // a presented payload beat stays put until accepted
    if (!(buf1.tvalid && !hs_b1)) begin
      if (bq1.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        buf1.tvalid = 1'b1;
        {buf1.tlast, buf1.tdata} = bq1[0];
      end else buf1.tvalid = 1'b0;
    end
    meta1.tvalid = meta_en1 && mq1.size() > 0;
    meta1.tdata  = (mq1.size() > 0) ? mq1[0] : 32'h0;
    case (tr_mode)
      0:       out1.tready = 1'b1;
      1:       out1.tready = ~out1.tready;
      default: out1.tready = 1'($urandom_range(0, 1));
    endcase
    if (rand_start) start1 = 1'($urandom_range(0, 1));
    buf2.tvalid = q2.size() > 0;
    if (q2.size() > 0) {buf2.tlast, buf2.tdata} = q2[0];
  endtask

  task automatic send1(input logic [31:0] meta, input int n, input logic [7:0] first,
                       input logic [7:0] step);
    int k = (n > 4) ? 4 : n;
    logic [7:0] d = first;
    mq1.push_back(meta);
    exp1.push_back({1'b0, meta});
    trunc1.push_back(n > 4);
    sent1++;
    if (n > 4) exp_errs1++;
    for (int i = 0; i < n; i++) begin
      bq1.push_back({i == n - 1, d});
      if (i < k) exp1.push_back({i == k - 1, 24'h0, d});
      d = d + step;
    end
  endtask

  task automatic wait1(input int budget);
    int b = budget;
    while ((exp1.size() > 0 || trunc1.size() > 0) && b > 0) begin tick(); b--; end
    if (b == 0) chk("timeout1", 0, 1);
  endtask

  initial begin
    int p, h, b;
    rstn1 = 0; rstn2 = 0; start1 = 0; start2 = 0;
    buf1.tvalid = 0; buf1.tdata = 0; buf1.tlast = 0;
    buf2.tvalid = 0; buf2.tdata = 0; buf2.tlast = 0;
    meta1.tvalid = 0; meta1.tdata = 0; meta1.tlast = 0;
    meta2.tvalid = 1; meta2.tdata = 32'h5; meta2.tlast = 0;
    out1.tready = 1; out2.tready = 1;
    repeat (3) tick();
    chk("rst_tvalid", out1.tvalid, 0);
    chk("rst_tdata", out1.tdata, 0);
    chk("rst_tlast", out1.tlast, 0);
    chk("rst_meta_rdy", meta1.tready, 0);
    chk("rst_rdy", rdy1, 0);
    chk("rst_err", err1, 0);
    chk("rst_buf_rdy", buf1.tready, 0);
    rstn1 = 1; rstn2 = 1;
    tick();

    // directed header packet, sink always ready
    start1 = 1;
    send1(32'hCAFE0001, 4, 8'h11, 8'h11);
    wait1(200);
    chk("pops_a", pops1, 1);
    chk("errs_a", errs1, 0);

    // same packet, sink toggling
    tr_mode = 1;
    send1(32'hCAFE0001, 4, 8'h11, 8'h11);
    wait1(200);
    chk("pops_b", pops1, 2);

    // over-length packet truncated at 4 beats
    tr_mode = 0;
    send1(32'hBEEF0006, 6, 8'h01, 8'h01);
    wait1(200);
    chk("pops_c", pops1, 3);
    chk("errs_c", errs1, 1);
    chk("buf_drained", bq1.size(), 0);

    // grant without metadata is ignored
    meta_en1 = 0;
    send1(32'h0BAD0002, 2, 8'hA0, 8'h01);
    repeat (6) begin
      tick();
      chk("rdy_nometa", rdy1, 0);
      chk("idle_out", out1.tvalid, 0);
    end
    meta_en1 = 1;
    wait1(200);
    chk("pops_d", pops1, 4);

    // randomised traffic
    tr_mode = 2; gaps = 1; rand_start = 1;
    for (int i = 0; i < 20; i++)
      send1($urandom, int'($urandom_range(1, 7)), 8'($urandom), 8'($urandom));
    wait1(4000);
    chk("pops_rand", pops1, sent1);
    chk("errs_rand", errs1, exp_errs1);

    // back-to-back single-beat packets, grant tied high
    per_chk = 1;
    for (int i = 0; i < 6; i++) begin
      q2.push_back({1'b1, 8'(8'hA0 + i)});
      exp2.push_back({1'b1, 24'h0, 8'(8'hA0 + i)});
    end
    start2 = 1;
    b = 100;
    while (exp2.size() > 0 && b > 0) begin tick(); b--; end
    if (b == 0) chk("timeout2", 0, 1);
    repeat (3) tick();
    chk("pops_b2b", pops2, 6);
    chk("hs_b2b", hs2, 6);
    per_chk = 0;

    // reset in the middle of a 10-beat packet
    p = pops2; h = hs2;
    for (int i = 0; i < 10; i++) begin
      q2.push_back({i == 9, 8'(8'h30 + i)});
      exp2.push_back({i == 9, 24'h0, 8'(8'h30 + i)});
    end
    b = 100;
    while (hs2 < h + 4 && b > 0) begin tick(); b--; end
    if (b == 0) chk("timeout3", 0, 1);
    rstn2 = 0; start2 = 0;
    tick();
    rstn2 = 1;
    q2.delete(); exp2.delete(); buf2.tvalid = 0;
    chk("mid_tvalid", out2.tvalid, 0);
    chk("mid_tdata", out2.tdata, 0);
    chk("mid_tlast", out2.tlast, 0);
    chk("mid_meta_rdy", meta2.tready, 0);
    chk("mid_rdy", rdy2, 0);
    chk("mid_err", err2, 0);
    repeat (4) tick();
    chk("mid_no_pop", pops2, p);
    chk("mid_quiet", out2.tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
